// File: rtl/mont_exp_ctrl_pkg.sv
// Shared defaults and encodings for the Montgomery exponentiation scheduler.
package mont_exp_ctrl_pkg;

  localparam int DEF_WIDTH  = 1024;
  localparam int DEF_ELEN_W = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_TOMONT   = 2'd0,
    OP_SQ       = 2'd1,
    OP_MUL      = 2'd2,
    OP_FROMMONT = 2'd3
  } op_t;

endpackage

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one shared Montgomery
// multiplier through a start/done handshake.
module mont_exp_ctrl
  import mont_exp_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ELEN_W = DEF_ELEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  in_x,
  input  logic [WIDTH-1:0]  in_e,
  input  logic [ELEN_W-1:0] e_len,
  input  logic [WIDTH-1:0]  in_r,
  input  logic [WIDTH-1:0]  in_r2,
  input  logic [WIDTH-1:0]  in_m,
  output logic              mul_start,
  output logic [WIDTH-1:0]  mul_a,
  output logic [WIDTH-1:0]  mul_b,
  output logic [WIDTH-1:0]  mul_m,
  input  logic [WIDTH-1:0]  mul_result,
  input  logic              mul_done,
  output logic [WIDTH-1:0]  result,
  output logic              busy,
  output logic              done
);

  state_t            state;
  op_t               op;
  logic [WIDTH-1:0]  x_q, r2_q, acc, xt, e_sh;
  logic [ELEN_W-1:0] idx;
  logic              no_rounds;
  logic [ELEN_W-1:0] elen_c;
  logic [ELEN_W:0]   lead;

  // Left-align the used exponent bits once so each round only looks at the MSB.
  always_comb begin
    elen_c = (e_len > ELEN_W'(WIDTH)) ? ELEN_W'(WIDTH) : e_len;
    lead   = (ELEN_W+1)'(WIDTH) - {1'b0, elen_c};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op        <= OP_TOMONT;
      x_q       <= '0;
      r2_q      <= '0;
      acc       <= '0;
      xt        <= '0;
      e_sh      <= '0;
      idx       <= '0;
      no_rounds <= 1'b0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_m     <= '0;
      result    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: if (start) begin
          x_q       <= in_x;
          r2_q      <= in_r2;
          mul_m     <= in_m;
          acc       <= in_r;
          e_sh      <= in_e << lead;
          idx       <= (elen_c == '0) ? '0 : elen_c - ELEN_W'(1);
          no_rounds <= (elen_c == '0);
          op        <= OP_TOMONT;
          busy      <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: begin
          case (op)
            OP_TOMONT:   begin mul_a <= x_q; mul_b <= r2_q;      end
            OP_SQ:       begin mul_a <= acc; mul_b <= acc;       end
            OP_MUL:      begin mul_a <= acc; mul_b <= xt;        end
            OP_FROMMONT: begin mul_a <= acc; mul_b <= WIDTH'(1); end
          endcase
          mul_start <= 1'b1;
          state     <= WAIT;
        end
        WAIT: if (mul_done) begin
          state <= ISSUE;
          case (op)
            OP_TOMONT: begin
              xt <= mul_result;
              op <= no_rounds ? OP_FROMMONT : OP_SQ;
            end
            OP_SQ, OP_MUL: begin
              acc <= mul_result;
              if (op == OP_SQ && e_sh[WIDTH-1]) begin
                op <= OP_MUL;
              end else begin
                // Round finished: advance to the next exponent bit or leave the loop.
                e_sh <= e_sh << 1;
                if (idx == '0) begin
                  op <= OP_FROMMONT;
                end else begin
                  idx <= idx - ELEN_W'(1);
                  op  <= OP_SQ;
                end
              end
            end
            OP_FROMMONT: begin
              result <= mul_result;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= DONE;
            end
          endcase
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Directed bench: behavioural Montgomery multiplier with configurable latency.
module tb_mont_exp_ctrl;

  localparam int W  = 1024;
  localparam int EW = 11;
  localparam int TW = 2*W + 2;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [W-1:0]  in_x, in_e, in_r, in_r2, in_m;
  logic [EW-1:0] e_len;
  logic          mul_start, busy, done, mul_done;
  logic [W-1:0]  mul_a, mul_b, mul_m, mul_result, result;

  mont_exp_ctrl #(.WIDTH(W), .ELEN_W(EW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_x(in_x), .in_e(in_e), .e_len(e_len), .in_r(in_r), .in_r2(in_r2), .in_m(in_m),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m),
    .mul_result(mul_result), .mul_done(mul_done),
    .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [W-1:0] mont(input logic [W-1:0] a, b, m);
    logic [TW-1:0] t;
    t = TW'(a) * TW'(b);
    for (int i = 0; i < W; i++) begin
      if (t[0]) t = t + TW'(m);
      t = t >> 1;
    end
    if (t >= TW'(m)) t = t - TW'(m);
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] rmod(input logic [W-1:0] m);
    logic [TW-1:0] t;
    t = TW'(1) << W;
    t = t % TW'(m);
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, b, m);
    logic [TW-1:0] t;
    t = (TW'(a) * TW'(b)) % TW'(m);
    return t[W-1:0];
  endfunction

  // Multiplier model plus protocol monitors, all evaluated away from the active edge.
  int           lat = 3, cnt = 0, neg = 0, ndone = 0;
  int           starts = 0, dones = 0, gap_err = 0, stab_err = 0;
  bit           pend = 0, have_done = 0;
  logic         mdl_done = 1'b0, stray = 1'b0;
  logic [W-1:0] pa, pb, pm;

  assign mul_done = mdl_done | stray;

  initial mul_result = '0;

  always @(negedge clk) begin
    neg++;
    mdl_done = 1'b0;
    if (reset) begin
      pend = 0;
      have_done = 0;
    end else begin
      if (pend) begin
        if (mul_a !== pa || mul_b !== pb) stab_err++;
        if (cnt <= 1) begin
          mdl_done   = 1'b1;
          mul_result = mont(pa, pb, pm);
          pend       = 0;
          ndone      = neg;
          have_done  = 1;
        end else cnt--;
      end
      if (mul_start) begin
        starts++;
        if (have_done && (neg - ndone) != 2) gap_err++;
        pend = 1;
        cnt  = lat;
        pa   = mul_a;
        pb   = mul_b;
        pm   = mul_m;
      end
      if (done) begin
        dones++;
        have_done = 0;
      end
    end
  end

  int s0, d0;

  task automatic kick(input logic [W-1:0] x, e, input logic [EW-1:0] el, input logic [W-1:0] m);
    @(negedge clk);
    in_x = x; in_e = e; e_len = el; in_m = m;
    in_r = rmod(m); in_r2 = mulmod(rmod(m), rmod(m), m);
    s0 = starts; d0 = dones;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_run(input string tag, input logic [W-1:0] exp, input int nops);
    bit ok = 0;
    int g0 = gap_err, st0 = stab_err;
    for (int i = 0; i < nops * (lat + 4) + 50; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1; break; end
    end
    chk({tag, ".done_seen"}, W'(ok), W'(1));
    chk({tag, ".result"}, result, exp);
    chk({tag, ".busy_low"}, W'(busy), W'(0));
    repeat (3) @(negedge clk);
    chk({tag, ".done_once"}, W'(dones - d0), W'(1));
    chk({tag, ".mul_starts"}, W'(starts - s0), W'(nops));
    chk({tag, ".result_held"}, result, exp);
    chk({tag, ".gap"}, W'(gap_err), W'(g0));
    chk({tag, ".stable"}, W'(stab_err), W'(st0));
  endtask

  localparam logic [W-1:0] M1 = W'(1000003);

  initial begin
    logic [W-1:0] m3, e3, g3;
    int s1;
    reset = 1'b1; start = 1'b0;
    in_x = '0; in_e = '0; e_len = '0; in_r = '0; in_r2 = '0; in_m = '0;
    repeat (3) @(negedge clk);
    chk("rst.busy", W'(busy), W'(0));
    chk("rst.done", W'(done), W'(0));
    chk("rst.mul_start", W'(mul_start), W'(0));
    chk("rst.result", result, '0);
    chk("rst.mul_a", mul_a, '0);
    reset = 1'b0;

    // x=2, e=0b1010 over 4 bits
    lat = 3;
    kick(W'(2), W'(10), EW'(4), M1);
    chk("t1.busy_high", W'(busy), W'(1));
    finish_run("t1", W'(1024), 8);

    lat = 1;
    kick(W'(2), W'(10), EW'(4), M1);
    finish_run("t4.lat1", W'(1024), 8);

    lat = 600;
    kick(W'(5), W'(0), EW'(0), W'(97));
    finish_run("t2.elen0", W'(1), 2);

    // full-width exponent 2^1023+1 against a random odd modulus
    lat = 1;
    for (int i = 0; i < W/32; i++) m3[i*32 +: 32] = $urandom;
    m3[0] = 1'b1; m3[W-1] = 1'b1;
    e3 = '0; e3[W-1] = 1'b1; e3[0] = 1'b1;
    g3 = W'(3);
    for (int i = 0; i < W-1; i++) g3 = mulmod(g3, g3, m3);
    g3 = mulmod(g3, W'(3), m3);
    kick(W'(3), e3, EW'(W), m3);
    finish_run("t3.full", g3, 2 + W + 2);

    // e_len beyond WIDTH is clamped: 1024 rounds of e=10 still give 2^10
    kick(W'(2), W'(10), EW'(2047), M1);
    finish_run("clamp", W'(1024), 2 + W + 2);

    // start while busy must not disturb the latched job
    lat = 5;
    kick(W'(2), W'(10), EW'(4), M1);
    repeat (3) @(negedge clk);
    chk("t5.busy_mid", W'(busy), W'(1));
    in_x = W'(7); in_e = W'(3); e_len = EW'(2); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_run("t5.start_busy", W'(1024), 8);

    // reset during WAIT followed by a stray completion pulse
    lat = 20;
    kick(W'(2), W'(10), EW'(4), M1);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    s1 = starts;
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6.busy", W'(busy), W'(0));
    chk("t6.done", W'(done), W'(0));
    chk("t6.result", result, '0);
    chk("t6.mul_a", mul_a, '0);
    chk("t6.no_starts", W'(starts - s1), W'(0));
    lat = 2;
    kick(W'(2), W'(10), EW'(4), M1);
    finish_run("t6.after", W'(1024), 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
